// File: rtl/hazard_stall_unit_if.sv
// Bundle between the pipeline stages and the hazard stall unit.
// It carries the hazard inputs from ID/EX/MEM and the pipeline-register enables.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             uses_rt_id;
    logic [4:0]       dest_ex;
    logic             memread_ex;
    logic             branch_taken_ex;
    logic             jump_id;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport slave (
        input  rs_id, rt_id, uses_rt_id, dest_ex, memread_ex,
               branch_taken_ex, jump_id, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
               pipe_freeze, mem_timeout, stall_count, flush_count
    );

    modport master (
        output rs_id, rt_id, uses_rt_id, dest_ex, memread_ex,
               branch_taken_ex, jump_id, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
               pipe_freeze, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// It covers load-use stalls, branch/jump flushes, and data-memory wait freezes with a timeout.
module hazard_stall_unit #(
    parameter int CNT_W        = 16,
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT = 8'(MAX_MEM_WAIT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic lu;
    logic wait_now;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_freeze;

    assign lu = bus.memread_ex && (bus.dest_ex != 5'd0) &&
                ((bus.dest_ex == bus.rs_id) ||
                 (bus.uses_rt_id && (bus.dest_ex == bus.rt_id)));
    assign wait_now = bus.mem_req && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Ready wins over the timeout when both land in the same cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (wait_now) begin
                    wait_cnt_d = 8'd1;
                    state_d    = (MAX_WAIT == 8'd1) ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == MAX_WAIT) begin
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (rst) begin
            if ((state_q != RUN) || wait_now) begin
                pipe_freeze = 1'b1;
            end else if (bus.branch_taken_ex) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                idex_bubble = 1'b1;
            end else if (bus.jump_id) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
            end
        end
    end

    // Statistics counters saturate at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (ifid_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.pipe_freeze = pipe_freeze;
    assign bus.mem_timeout = (state_q == ERROR);
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit.
// Control outputs are packed as {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}.
module tb_hazard_stall_unit;

    localparam int CNT_W        = 4;
    localparam int MAX_MEM_WAIT = 15;

    localparam logic [5:0] C_RESET  = 6'b000000;
    localparam logic [5:0] C_IDLE   = 6'b110000;
    localparam logic [5:0] C_LU     = 6'b000100;
    localparam logic [5:0] C_BRANCH = 6'b111100;
    localparam logic [5:0] C_JUMP   = 6'b111000;
    localparam logic [5:0] C_FREEZE = 6'b000010;
    localparam logic [5:0] C_ERROR  = 6'b000011;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_stall_unit #(
        .CNT_W        (CNT_W),
        .MAX_MEM_WAIT (MAX_MEM_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int sat(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                  input logic [4:0] dest, input logic memread, input logic br,
                                  input logic jump, input logic req, input logic ready);
        bus.rs_id           = rs;
        bus.rt_id           = rt;
        bus.uses_rt_id      = uses_rt;
        bus.dest_ex         = dest;
        bus.memread_ex      = memread;
        bus.branch_taken_ex = br;
        bus.jump_id         = jump;
        bus.mem_req         = req;
        bus.mem_ready       = ready;
        #1;
    endtask

    task automatic check_output(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
               bus.idex_bubble, bus.pipe_freeze, bus.mem_timeout};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int stall_exp, input int flush_exp);
        check_output({tag, "_stall"}, int'(bus.stall_count), stall_exp);
        check_output({tag, "_flush"}, int'(bus.flush_count), flush_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check_ctrl("reset_ctrl", C_RESET);
        check_counts("reset", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_ctrl("idle_ctrl", C_IDLE);
        tick();

        apply_stimulus(5, 0, 0, 5, 1, 0, 0, 0, 0);
        check_ctrl("lu_rs_ctrl", C_LU);
        tick();
        check_counts("lu_rs", 1, 0);
        apply_stimulus(5, 0, 0, 0, 0, 0, 0, 0, 0);
        check_ctrl("lu_bubble_gone", C_IDLE);
        tick();
        check_counts("lu_after", 1, 0);
        apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check_ctrl("lu_dest0", C_IDLE);
        tick();
        check_counts("lu_dest0", 1, 0);

        apply_stimulus(3, 5, 1, 5, 1, 1, 0, 0, 0);
        check_ctrl("lu_rt_branch", C_BRANCH);
        tick();
        check_counts("branch", 1, 1);
        apply_stimulus(3, 5, 0, 5, 1, 0, 0, 0, 0);
        check_ctrl("rt_unused", C_IDLE);
        tick();
        check_counts("rt_unused", 1, 1);

        apply_stimulus(5, 0, 0, 5, 1, 0, 1, 0, 0);
        check_ctrl("lu_jump_stall", C_LU);
        tick();
        check_counts("lu_jump", 2, 1);
        apply_stimulus(5, 0, 0, 0, 0, 0, 1, 0, 0);
        check_ctrl("jump_deferred", C_JUMP);
        tick();
        check_counts("jump", 2, 2);

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_ctrl("mem_wait1", C_FREEZE);
        tick();
        check_counts("mem_wait1", 3, 2);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1, 0);
        check_ctrl("mem_wait2_branch", C_FREEZE);
        tick();
        check_counts("mem_wait2", 4, 2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_ctrl("mem_wait3", C_FREEZE);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check_ctrl("mem_ready_frozen", C_FREEZE);
        tick();
        check_counts("mem_done", 6, 2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_ctrl("mem_released", C_IDLE);
        tick();
        check_counts("mem_released", 6, 2);

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= MAX_MEM_WAIT; i++) begin
            check_ctrl("timeout_wait", C_FREEZE);
            tick();
            check_output("timeout_stall", int'(bus.stall_count), sat(6 + i));
        end
        check_ctrl("timeout_error", C_ERROR);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        check_ctrl("error_sticky", C_ERROR);
        #1;
        rst = 1'b0;
        #1;
        check_ctrl("async_reset_ctrl", C_RESET);
        check_counts("async_reset", 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_ctrl("post_reset_idle", C_IDLE);

        apply_stimulus(7, 0, 0, 7, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 19; i++) begin
            tick();
            check_output("stall_sat", int'(bus.stall_count), sat(i));
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 19; i++) begin
            tick();
            check_output("flush_sat", int'(bus.flush_count), sat(i));
        end

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i < MAX_MEM_WAIT; i++) begin
            tick();
        end
        check_ctrl("ready_wins_before", C_FREEZE);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_ctrl("ready_wins_run", C_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline.
- Covers the hazards forwarding cannot resolve:
  - load-use: bubble ID/EX, hold PC and IF/ID;
  - control: flush on taken branch resolved in EX, or on jump decoded in ID;
  - multi-cycle data-memory access: freeze the whole pipeline until `mem_ready`.
- Maintains a memory-wait timeout and saturating stall/flush statistics counters.
- Sits beside the forwarding logic, between the hazard inputs from the ID/EX/MEM stages and the pipeline-register enables.

Parameters:
- CNT_W, 16, width of `stall_count` and `flush_count`.
- MAX_MEM_WAIT, 15, consecutive `mem_ready`-low wait cycles before timeout (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs_id  in  5  source register rs of the instruction in ID.
- rt_id  in  5  source register rt of the instruction in ID.
- uses_rt_id  in  1  ID instruction reads rt as a source.
- dest_ex  in  5  destination register of the instruction in EX.
- memread_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  branch resolved taken in EX.
- jump_id  in  1  jump decoded in ID.
- mem_req  in  1  MEM stage is issuing a load/store this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- mem_timeout  out  1  sticky memory timeout error.
- stall_count  out  CNT_W  cycles with `pc_write` = 0.
- flush_count  out  CNT_W  cycles with `ifid_flush` = 1.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - state = RUN; wait counter = 0; `mem_timeout` = 0; `stall_count` = 0; `flush_count` = 0.
  - All control outputs forced 0, including `pc_write` and `ifid_write`. The pipeline does not advance in reset.
  - Reset mid-freeze or mid-stall aborts immediately.
- States:
  - RUN: normal operation.
  - MEM_WAIT: waiting on data memory.
  - ERROR: timeout reached.
- Definitions:
  - `lu` = `memread_ex` && `dest_ex` != 0 && (`dest_ex` == `rs_id` || (`uses_rt_id` && `dest_ex` == `rt_id`)).
  - `wait_now` = `mem_req` && !`mem_ready`.
- Freeze (all control outputs are combinational):
  - `pipe_freeze` = (state == MEM_WAIT) || (state == ERROR) || (state == RUN && `wait_now`).
  - While `pipe_freeze` = 1: `pc_write` = 0, `ifid_write` = 0, `ifid_flush` = 0, `idex_bubble` = 0. Hazard inputs are held stable and re-evaluated after release.
- Priority when not frozen:
  1. `branch_taken_ex`: `ifid_flush` = 1, `idex_bubble` = 1, `pc_write` = 1, `ifid_write` = 1. Load-use in the same cycle is ignored because the ID instruction is wrong-path.
  2. `lu`: `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1, `ifid_flush` = 0. A `jump_id` in the same cycle is deferred; the jump is still in ID next cycle.
  3. `jump_id`: `ifid_flush` = 1, `pc_write` = 1, `ifid_write` = 1.
  4. Otherwise: `pc_write` = 1, `ifid_write` = 1, `ifid_flush` = 0, `idex_bubble` = 0.
- Load-use is a single-cycle stall: the bubble removes the load from EX the following cycle.
- `dest_ex` = 0 never stalls.
- Transitions:
  - RUN → MEM_WAIT on `wait_now`; wait counter := 1.
  - MEM_WAIT → RUN when `mem_ready` = 1. That cycle is still frozen; the pipeline advances on the next cycle.
  - In MEM_WAIT with `mem_ready` = 0: wait counter += 1. When the counter reaches MAX_MEM_WAIT → ERROR.
  - `mem_ready` arriving in the same cycle the counter would reach MAX returns to RUN (ready wins).
  - ERROR: `mem_timeout` = 1, `pipe_freeze` = 1; held until reset.
- Counters:
  - `stall_count` += 1 each clock edge with `pc_write` = 0 while not in reset.
  - `flush_count` += 1 each clock edge with `ifid_flush` = 1.
  - Both saturate at all-ones; no wrap.

Test Plan:
- lw r5 in EX (`memread_ex` = 1, `dest_ex` = 5), `rs_id` = 5 → exactly 1 cycle of `pc_write` = 0, `ifid_write` = 0, `idex_bubble` = 1; `stall_count` = 1. Repeat with `dest_ex` = 0 → no stall.
- `lu` (`rt_id` = 5, `uses_rt_id` = 1) together with `branch_taken_ex` = 1 → `ifid_flush` = 1, `idex_bubble` = 1, `pc_write` = 1; `flush_count` = 1. Repeat with `uses_rt_id` = 0 and branch low → no stall.
- `lu` + `jump_id` in the same cycle → stall cycle with `ifid_flush` = 0, then the next cycle `ifid_flush` = 1, `pc_write` = 1.
- `mem_req` = 1, `mem_ready` low for 3 cycles then high → `pipe_freeze` = 1 for 4 cycles; all other enables 0 during freeze; state returns to RUN; `stall_count` = 4.
- `mem_ready` held low with MAX_MEM_WAIT = 15 → ERROR entered after 15 wait cycles; `mem_timeout` = 1 and `pipe_freeze` stay high; assert `rst` = 0 asynchronously → all outputs and counters return to 0 immediately.
- Force 2^CNT_W + 3 stall cycles (CNT_W = 4 in bench) → `stall_count` saturates at 15.
